// File: rtl/maze_pkg.sv
// Shared definitions for the maze player controller: grid defaults, start/goal
// coordinates, direction and state encodings, and the wall-map cell index.
package maze_pkg;

  localparam int unsigned GRID_W_DEF  = 16;
  localparam int unsigned GRID_H_DEF  = 12;
  localparam int unsigned START_X_DEF = 0;
  localparam int unsigned START_Y_DEF = 0;
  localparam int unsigned GOAL_X_DEF  = 15;
  localparam int unsigned GOAL_Y_DEF  = 11;
  localparam int unsigned CNT_W_DEF   = 16;

  typedef enum logic [2:0] {
    DIR_NONE = 3'd0,
    DIR_U    = 3'd1,
    DIR_D    = 3'd2,
    DIR_L    = 3'd3,
    DIR_R    = 3'd4
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_CHK  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Row-major wall-map index
  function automatic int unsigned cell_index(input int unsigned x,
                                             input int unsigned y,
                                             input int unsigned w);
    return y * w + x;
  endfunction

endpackage

// File: rtl/maze_player_ctrl_if.sv
// Bus bundle between the player controller and its neighbours.
//   btn_*_pulse : one-cycle debounced button requests (in to controller)
//   wall_rd/addr: wall ROM read port, wall_data returns one cycle later
//   player_x/y, move_count, bump, level_done, busy : status to display logic
// master = controller side, slave = buttons/ROM/display side.
interface maze_player_ctrl_if import maze_pkg::*; #(
  parameter int unsigned GRID_W = GRID_W_DEF,
  parameter int unsigned GRID_H = GRID_H_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
);
  localparam int unsigned AW = $clog2(GRID_W * GRID_H);
  localparam int unsigned XW = $clog2(GRID_W);
  localparam int unsigned YW = $clog2(GRID_H);

  logic             btn_u_pulse;
  logic             btn_d_pulse;
  logic             btn_l_pulse;
  logic             btn_r_pulse;
  logic             btn_c_pulse;
  logic             wall_rd;
  logic [AW-1:0]    wall_addr;
  logic             wall_data;
  logic [XW-1:0]    player_x;
  logic [YW-1:0]    player_y;
  logic [CNT_W-1:0] move_count;
  logic             bump;
  logic             level_done;
  logic             busy;

  modport master (
    input  btn_u_pulse, btn_d_pulse, btn_l_pulse, btn_r_pulse, btn_c_pulse,
    input  wall_data,
    output wall_rd, wall_addr, player_x, player_y, move_count, bump,
    output level_done, busy
  );

  modport slave (
    output btn_u_pulse, btn_d_pulse, btn_l_pulse, btn_r_pulse, btn_c_pulse,
    output wall_data,
    input  wall_rd, wall_addr, player_x, player_y, move_count, bump,
    input  level_done, busy
  );

endinterface

// File: rtl/maze_dir_arbiter.sv
// Combinational direction arbiter: priority U>D>L>R, computes the target cell
// one step away and flags targets that would leave the grid.
//   i_btn_*       : directional requests
//   i_x/i_y       : current player cell
//   o_dir_c       : winning direction (DIR_NONE if no request)
//   o_target_*_c  : target cell (equals current cell when out of bounds)
//   o_oob_c       : target lies outside the grid
module maze_dir_arbiter import maze_pkg::*; #(
  parameter int unsigned GRID_W = GRID_W_DEF,
  parameter int unsigned GRID_H = GRID_H_DEF,
  localparam int unsigned XW = $clog2(GRID_W),
  localparam int unsigned YW = $clog2(GRID_H)
) (
  input  logic          i_btn_u,
  input  logic          i_btn_d,
  input  logic          i_btn_l,
  input  logic          i_btn_r,
  input  logic [XW-1:0] i_x,
  input  logic [YW-1:0] i_y,
  output dir_e          o_dir_c,
  output logic [XW-1:0] o_target_x_c,
  output logic [YW-1:0] o_target_y_c,
  output logic          o_oob_c
);

  // Priority encode and bounds check; losers are simply dropped
  always_comb begin
    o_dir_c      = DIR_NONE;
    o_target_x_c = i_x;
    o_target_y_c = i_y;
    o_oob_c      = 1'b0;
    if (i_btn_u) begin
      o_dir_c = DIR_U;
      o_oob_c = (i_y == '0);
      if (!o_oob_c) o_target_y_c = i_y - YW'(1);
    end else if (i_btn_d) begin
      o_dir_c = DIR_D;
      o_oob_c = (i_y == YW'(GRID_H - 1));
      if (!o_oob_c) o_target_y_c = i_y + YW'(1);
    end else if (i_btn_l) begin
      o_dir_c = DIR_L;
      o_oob_c = (i_x == '0);
      if (!o_oob_c) o_target_x_c = i_x - XW'(1);
    end else if (i_btn_r) begin
      o_dir_c = DIR_R;
      o_oob_c = (i_x == XW'(GRID_W - 1));
      if (!o_oob_c) o_target_x_c = i_x + XW'(1);
    end
  end

endmodule

// File: rtl/maze_player_ctrl.sv
// Maze player controller: takes button pulses, checks the target cell against
// the wall ROM (1-cycle read latency) and moves the player, counting moves.
//   Clk, Reset : clock and synchronous active-high reset
//   bus        : button pulses, wall ROM port, and position/status outputs
module maze_player_ctrl import maze_pkg::*; #(
  parameter int unsigned GRID_W  = GRID_W_DEF,
  parameter int unsigned GRID_H  = GRID_H_DEF,
  parameter int unsigned START_X = START_X_DEF,
  parameter int unsigned START_Y = START_Y_DEF,
  parameter int unsigned GOAL_X  = GOAL_X_DEF,
  parameter int unsigned GOAL_Y  = GOAL_Y_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic               Clk,
  input  logic               Reset,
  maze_player_ctrl_if.master bus
);

  localparam int unsigned AW = $clog2(GRID_W * GRID_H);
  localparam int unsigned XW = $clog2(GRID_W);
  localparam int unsigned YW = $clog2(GRID_H);

  state_e           r_state, w_state_nxt;
  logic [XW-1:0]    r_x, r_tx, w_x_nxt, w_tx_nxt;
  logic [YW-1:0]    r_y, r_ty, w_y_nxt, w_ty_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [AW-1:0]    r_addr, w_addr_nxt;
  logic             r_wall_rd, w_wall_rd_nxt;
  logic             r_bump, w_bump_nxt;
  logic             r_level_done, r_busy;

  dir_e             w_dir;
  logic [XW-1:0]    w_tgt_x;
  logic [YW-1:0]    w_tgt_y;
  logic             w_oob;
  logic             w_req;
  logic             w_goal_hit;

  maze_dir_arbiter #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H)
  ) u_arb (
    .i_btn_u      (bus.btn_u_pulse),
    .i_btn_d      (bus.btn_d_pulse),
    .i_btn_l      (bus.btn_l_pulse),
    .i_btn_r      (bus.btn_r_pulse),
    .i_x          (r_x),
    .i_y          (r_y),
    .o_dir_c      (w_dir),
    .o_target_x_c (w_tgt_x),
    .o_target_y_c (w_tgt_y),
    .o_oob_c      (w_oob)
  );

  assign w_req      = (w_dir != DIR_NONE);
  assign w_goal_hit = !bus.wall_data && (r_tx == XW'(GOAL_X)) && (r_ty == YW'(GOAL_Y));

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (!bus.btn_c_pulse && w_req && !w_oob) w_state_nxt = ST_RD;
      ST_RD:   w_state_nxt = ST_CHK;
      ST_CHK:  w_state_nxt = w_goal_hit ? ST_DONE : ST_IDLE;
      ST_DONE: if (bus.btn_c_pulse) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values for the datapath and registered outputs; the ROM strobe is
  // launched on the IDLE->RD edge so it is high for exactly the RD cycle
  always_comb begin
    w_x_nxt       = r_x;
    w_y_nxt       = r_y;
    w_tx_nxt      = r_tx;
    w_ty_nxt      = r_ty;
    w_cnt_nxt     = r_cnt;
    w_addr_nxt    = r_addr;
    w_wall_rd_nxt = 1'b0;
    w_bump_nxt    = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (bus.btn_c_pulse) begin
          w_x_nxt   = XW'(START_X);
          w_y_nxt   = YW'(START_Y);
          w_cnt_nxt = '0;
        end else if (r_state == ST_IDLE && w_req) begin
          if (w_oob) begin
            w_bump_nxt = 1'b1;
          end else begin
            w_tx_nxt      = w_tgt_x;
            w_ty_nxt      = w_tgt_y;
            w_wall_rd_nxt = 1'b1;
            w_addr_nxt    = AW'(cell_index(32'(w_tgt_x), 32'(w_tgt_y), GRID_W));
          end
        end
      end
      ST_CHK: begin
        if (bus.wall_data) begin
          w_bump_nxt = 1'b1;
        end else begin
          w_x_nxt = r_tx;
          w_y_nxt = r_ty;
          if (r_cnt != '1) w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_x          <= XW'(START_X);
      r_y          <= YW'(START_Y);
      r_tx         <= XW'(START_X);
      r_ty         <= YW'(START_Y);
      r_cnt        <= '0;
      r_addr       <= '0;
      r_wall_rd    <= 1'b0;
      r_bump       <= 1'b0;
      r_level_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_x          <= w_x_nxt;
      r_y          <= w_y_nxt;
      r_tx         <= w_tx_nxt;
      r_ty         <= w_ty_nxt;
      r_cnt        <= w_cnt_nxt;
      r_addr       <= w_addr_nxt;
      r_wall_rd    <= w_wall_rd_nxt;
      r_bump       <= w_bump_nxt;
      r_level_done <= (w_state_nxt == ST_DONE);
      r_busy       <= (w_state_nxt != ST_IDLE);
    end
  end

  assign bus.wall_rd    = r_wall_rd;
  assign bus.wall_addr  = r_addr;
  assign bus.player_x   = r_x;
  assign bus.player_y   = r_y;
  assign bus.move_count = r_cnt;
  assign bus.bump       = r_bump;
  assign bus.level_done = r_level_done;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_maze_player_ctrl.sv
// Testbench for maze_player_ctrl: wall ROM model, table of directed requests,
// hand-written multi-cycle sequences and a randomized run against a
// cell-level reference model of the player.
module tb_maze_player_ctrl;

  logic Clk;
  logic Reset;

  maze_player_ctrl_if bus ();

  maze_player_ctrl dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Wall ROM: 1-cycle latency; returns noise when not read
  bit walls [0:191];
  initial bus.wall_data = 1'b0;
  always @(posedge Clk) begin
    if (bus.wall_rd && bus.wall_addr < 8'd192) bus.wall_data <= walls[bus.wall_addr];
    else                                       bus.wall_data <= 1'($urandom);
  end

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  int mx, my, mcnt, mdone;

  typedef struct {
    logic u, d, l, r, c;
    int   ex, ey, ecnt, erd, eaddr, ebump;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_walls();
    for (int i = 0; i < 192; i++) walls[i] = 1'b0;
  endtask

  task automatic set_btns(input logic u, d, l, r, c);
    bus.btn_u_pulse = u;
    bus.btn_d_pulse = d;
    bus.btn_l_pulse = l;
    bus.btn_r_pulse = r;
    bus.btn_c_pulse = c;
  endtask

  // One request: pulse for one cycle, then watch four cycles
  task automatic run_req(input logic u, d, l, r, c,
                         input int ex, ey, ecnt, erd, eaddr, ebump, edone,
                         input string nm);
    int rd_n, rd_k, rd_addr, bump_n, bump_k, addr_k2;
    rd_n = 0; rd_k = 0; rd_addr = 0; bump_n = 0; bump_k = 0; addr_k2 = 0;
    set_btns(u, d, l, r, c);
    @(negedge Clk);
    set_btns(0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(negedge Clk);
      if (bus.wall_rd) begin
        rd_n++;
        if (rd_k == 0) rd_k = k;
        rd_addr = int'(bus.wall_addr);
      end
      if (bus.bump) begin
        bump_n++;
        if (bump_k == 0) bump_k = k;
      end
      if (k == 2) addr_k2 = int'(bus.wall_addr);
    end
    check({nm, " rd_count"}, rd_n, erd);
    if (erd != 0) begin
      check({nm, " rd_cycle"}, rd_k, 1);
      check({nm, " rd_addr"}, rd_addr, eaddr);
      check({nm, " addr_hold"}, addr_k2, eaddr);
    end
    check({nm, " bump_count"}, bump_n, ebump);
    if (ebump != 0) check({nm, " bump_cycle"}, bump_k, (erd != 0) ? 3 : 1);
    check({nm, " x"}, int'(bus.player_x), ex);
    check({nm, " y"}, int'(bus.player_y), ey);
    check({nm, " cnt"}, int'(bus.move_count), ecnt);
    check({nm, " done"}, int'(bus.level_done), edone);
    check({nm, " busy"}, int'(bus.busy), edone);
  endtask

  // Reference model: cell-level rules, then apply and compare
  task automatic model_req(input logic u, d, l, r, c, input string nm);
    int tx, ty, erd, eaddr, ebump;
    erd = 0; eaddr = 0; ebump = 0;
    if (c) begin
      mx = 0; my = 0; mcnt = 0; mdone = 0;
    end else if (mdone == 0 && (u || d || l || r)) begin
      tx = mx; ty = my;
      if (u)      ty = ty - 1;
      else if (d) ty = ty + 1;
      else if (l) tx = tx - 1;
      else        tx = tx + 1;
      if (tx < 0 || tx >= 16 || ty < 0 || ty >= 12) begin
        ebump = 1;
      end else begin
        erd   = 1;
        eaddr = ty * 16 + tx;
        if (walls[eaddr]) begin
          ebump = 1;
        end else begin
          mx = tx; my = ty;
          if (mcnt < 65535) mcnt++;
          if (mx == 15 && my == 11) mdone = 1;
        end
      end
    end
    run_req(u, d, l, r, c, mx, my, mcnt, erd, eaddr, ebump, mdone, nm);
  endtask

  initial begin
    int rdc;
    set_btns(0, 0, 0, 0, 0);
    clear_walls();
    walls[17] = 1'b1;

    tbl[0]  = '{0,0,0,1,0, 1,0,1, 1, 1,0};
    tbl[1]  = '{0,0,1,0,0, 0,0,2, 1, 0,0};
    tbl[2]  = '{0,0,1,0,0, 0,0,2, 0, 0,1};
    tbl[3]  = '{1,0,0,0,0, 0,0,2, 0, 0,1};
    tbl[4]  = '{0,0,0,1,0, 1,0,3, 1, 1,0};
    tbl[5]  = '{0,1,0,0,0, 1,0,3, 1,17,1};
    tbl[6]  = '{1,1,1,1,0, 1,0,3, 0, 0,1};
    tbl[7]  = '{0,1,1,1,0, 1,0,3, 1,17,1};
    tbl[8]  = '{0,0,1,1,0, 0,0,4, 1, 0,0};
    tbl[9]  = '{0,0,0,1,1, 0,0,0, 0, 0,0};
    tbl[10] = '{0,1,0,0,0, 0,1,1, 1,16,0};
    tbl[11] = '{0,0,0,1,0, 0,1,1, 1,17,1};
    tbl[12] = '{0,1,0,1,0, 0,2,2, 1,32,0};
    tbl[13] = '{0,0,0,0,0, 0,2,2, 0, 0,0};

    // Reset values
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    check("rst x", int'(bus.player_x), 0);
    check("rst y", int'(bus.player_y), 0);
    check("rst cnt", int'(bus.move_count), 0);
    check("rst bump", int'(bus.bump), 0);
    check("rst done", int'(bus.level_done), 0);
    check("rst busy", int'(bus.busy), 0);
    check("rst wall_rd", int'(bus.wall_rd), 0);
    check("rst wall_addr", int'(bus.wall_addr), 0);
    Reset = 1'b0;
    @(negedge Clk);

    // Directed table
    foreach (tbl[i])
      run_req(tbl[i].u, tbl[i].d, tbl[i].l, tbl[i].r, tbl[i].c,
              tbl[i].ex, tbl[i].ey, tbl[i].ecnt, tbl[i].erd, tbl[i].eaddr,
              tbl[i].ebump, 0, $sformatf("tbl%0d", i));

    // Simultaneous U/L/R at (1,1), extra R during RD is dropped
    clear_walls();
    run_req(0,0,0,0,1, 0,0,0, 0,0,0,0, "t4 restart");
    run_req(0,0,0,1,0, 1,0,1, 1,1,0,0, "t4 r");
    run_req(0,1,0,0,0, 1,1,2, 1,17,0,0, "t4 d");
    set_btns(1, 0, 1, 1, 0);
    @(negedge Clk);
    set_btns(0, 0, 0, 0, 0);
    rdc = bus.wall_rd ? 1 : 0;
    check("t4 rd_now", int'(bus.wall_rd), 1);
    check("t4 addr", int'(bus.wall_addr), 1);
    bus.btn_r_pulse = 1'b1;
    @(negedge Clk);
    bus.btn_r_pulse = 1'b0;
    if (bus.wall_rd) rdc++;
    repeat (5) begin
      @(negedge Clk);
      if (bus.wall_rd) rdc++;
    end
    check("t4 rd_total", rdc, 1);
    check("t4 x", int'(bus.player_x), 1);
    check("t4 y", int'(bus.player_y), 0);
    check("t4 cnt", int'(bus.move_count), 3);

    // Open path to the goal, DONE behaviour and restart
    run_req(0,0,0,0,1, 0,0,0, 0,0,0,0, "t5 restart");
    for (int i = 0; i < 15; i++)
      run_req(0,0,0,1,0, i+1,0,i+1, 1,i+1,0,0, $sformatf("t5 r%0d", i));
    for (int j = 0; j < 11; j++)
      run_req(0,1,0,0,0, 15,j+1,16+j, 1,(j+1)*16+15,0,(j == 10) ? 1 : 0,
              $sformatf("t5 d%0d", j));
    run_req(0,1,0,0,0, 15,11,26, 0,0,0,1, "t5 done_d");
    run_req(0,0,0,1,0, 15,11,26, 0,0,0,1, "t5 done_r");
    run_req(1,0,0,0,1, 0,0,0, 0,0,0,0, "t5 restart_done");

    // Reset during CHK with an open target
    run_req(0,0,0,1,0, 1,0,1, 1,1,0,0, "t6 r0");
    run_req(0,0,0,1,0, 2,0,2, 1,2,0,0, "t6 r1");
    set_btns(0, 0, 0, 1, 0);
    @(negedge Clk);
    set_btns(0, 0, 0, 0, 0);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("t6 x", int'(bus.player_x), 0);
    check("t6 y", int'(bus.player_y), 0);
    check("t6 cnt", int'(bus.move_count), 0);
    check("t6 bump", int'(bus.bump), 0);
    check("t6 busy", int'(bus.busy), 0);
    check("t6 wall_rd", int'(bus.wall_rd), 0);
    @(negedge Clk);
    check("t6 bump_after", int'(bus.bump), 0);
    check("t6 busy_after", int'(bus.busy), 0);

    // Randomized requests on a random wall map
    mx = 0; my = 0; mcnt = 0; mdone = 0;
    for (int i = 0; i < 192; i++) walls[i] = ($urandom_range(0, 3) == 0);
    walls[0] = 1'b0;
    for (int n = 0; n < 300; n++) begin
      logic u, d, l, r, c;
      u = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 2) == 0);
      l = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 31) == 0);
      model_req(u, d, l, r, c, $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/maze_player_ctrl.md
Name: maze_player_ctrl

Overview:
- Consumes single-cycle, debounced direction/center button pulses from the button-conditioning stage.
- Moves the player one cell on the maze grid, checking each target cell against the wall-map ROM over a 1-cycle-latency read port.
- Publishes player cell position, move count and level-complete status to the VGA renderer and the 7-segment display.
- Sits directly upstream of the display logic inside vga_top.

Parameters:
- GRID_W, 16, maze width in cells.
- GRID_H, 12, maze height in cells.
- START_X, 0, reset/restart column.
- START_Y, 0, reset/restart row.
- GOAL_X, 15, goal column.
- GOAL_Y, 11, goal row.
- CNT_W, 16, move counter width.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- btn_u_pulse  in  1  one-cycle up request
- btn_d_pulse  in  1  one-cycle down request
- btn_l_pulse  in  1  one-cycle left request
- btn_r_pulse  in  1  one-cycle right request
- btn_c_pulse  in  1  one-cycle restart request
- wall_rd  out  1  wall ROM read strobe
- wall_addr  out  AW=clog2(GRID_W*GRID_H)  cell index, y*GRID_W+x
- wall_data  in  1  1=wall; valid the cycle after wall_rd
- player_x  out  clog2(GRID_W)  current column
- player_y  out  clog2(GRID_H)  current row
- move_count  out  CNT_W  accepted moves since reset/restart
- bump  out  1  one-cycle pulse: move rejected (edge or wall)
- level_done  out  1  high while player is on goal
- busy  out  1  high outside IDLE

Behaviour:
- Reset is synchronous (sampled on posedge Clk, Reset=1) and dominates all other inputs, including mid-lookup. Reset values:
  - player_x=START_X, player_y=START_Y
  - move_count=0, bump=0, level_done=0, busy=0, wall_rd=0, wall_addr=0
  - state=IDLE
- States: IDLE, RD, CHK, DONE.
- IDLE, no pulse: hold.
- IDLE, btn_c_pulse:
  - player set to (START_X, START_Y); move_count cleared.
  - Remains IDLE.
  - btn_c has priority over all directions in the same cycle.
- IDLE, directional pulse:
  - Simultaneous pulses resolve by priority U>D>L>R; the losers are dropped.
  - Target = current position ±1 on the axis (U: y-1, D: y+1, L: x-1, R: x+1).
  - Target outside 0..GRID_W-1 / 0..GRID_H-1: bump=1 next cycle, no ROM read, stay IDLE.
  - Otherwise: latch target, go to RD.
- RD (1 cycle):
  - wall_rd=1, wall_addr=target index.
  - Go to CHK.
- CHK (1 cycle): sample wall_data.
  - wall_data=1: bump=1, position unchanged, go to IDLE.
  - wall_data=0: position<=target, move_count<=move_count+1 (saturates at all-ones), go to IDLE.
  - If the new position equals (GOAL_X, GOAL_Y), go to DONE instead.
- Latency: pulse sampled at edge N; wall_rd high cycle N+1; new position visible after edge N+2.
- Button pulses arriving in RD or CHK are ignored; there is no queueing.
- DONE:
  - level_done=1; directional pulses are ignored.
  - btn_c_pulse restarts: same as IDLE restart, level_done<=0, go to IDLE.
- bump is a single-cycle pulse; it is never high two cycles in a row for one request.
- wall_addr holds its last value when wall_rd=0.
- busy=1 in RD, CHK and DONE.

Decomposition:
- Shared package maze_pkg:
  - GRID_W/GRID_H defaults and START/GOAL coordinates.
  - Direction encoding (DIR_NONE, DIR_U, DIR_D, DIR_L, DIR_R).
  - State encoding.
  - Cell-index function, y*GRID_W+x.
- One natural sub-module: maze_dir_arbiter. It is combinational; it performs the priority encode and the bounds check, and outputs dir, target_x, target_y and out_of_bounds. The FSM, counter and registers stay in maze_player_ctrl.

Test Plan:
1. Reset, then R pulse, ROM returns wall_data=0 → wall_rd high one cycle with wall_addr=1; after two edges player=(1,0), move_count=1, bump=0.
2. From (0,0), L pulse → no wall_rd; bump pulses once; player stays (0,0); move_count=0.
3. From (1,0), D pulse, ROM returns wall_data=1 for addr 17 → bump pulse; player=(1,0); move_count unchanged.
4. U, L and R pulses in the same cycle at (1,1) → only U processed (wall_addr=1); an extra R pulse during RD is ignored; exactly one move counted.
5. Scripted open path to (15,11) → level_done=1 and busy=1; a further D pulse causes no wall_rd; btn_c → player=(0,0), move_count=0, level_done=0.
6. Reset asserted during CHK with wall_data=0 → next cycle player=(0,0), move_count=0, state IDLE, no bump.
